// File: rtl/game_match_ctrl.sv
// -----------------------------------------------------------------------------
// game_match_ctrl
//
// Purpose:
//   Match-level controller wrapped around a counter game stage. It starts a
//   match on request and fires one INIT pulse per round, carrying the load
//   value for that round. It scores each round from the rising edge of the
//   stage's GAMEOVER/WHO pair and leaves a fixed idle gap between rounds. The
//   match is declared once one side reaches ROUNDS_TO_WIN round wins. A
//   gameover edge with an invalid WHO code does not score. It raises a sticky
//   flag, and the round is replayed with the same round number and load value.
//
// Parameters:
//   ROUNDS_TO_WIN  round wins needed to take the match (1..15)
//   GAP_CYCLES     idle cycles between a finished round and the next INIT (1..255)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          begin a match (honoured only when idle or finished)
//   seed_value     load value for round 1, captured when start is accepted
//   gameover       GAMEOVER level from the counter game stage
//   who            WHO from the stage: 01 = loser side, 10 = winner side
//   init           one-cycle INIT pulse to the counter game stage
//   load_value     value the stage loads on init
//   winner_rounds  rounds scored by the winner side in this match
//   loser_rounds   rounds scored by the loser side in this match
//   round_num      index of the round in play, starting at 1
//   busy           match in progress (INIT_PULSE, PLAY or GAP)
//   match_over     match finished (DONE)
//   match_winner   1 = winner side took the match; valid while match_over
//   bad_who        sticky: a gameover edge carried WHO = 00 or 11
// -----------------------------------------------------------------------------
module game_match_ctrl #(
    parameter int unsigned ROUNDS_TO_WIN = 3,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] seed_value,
    input  logic       gameover,
    input  logic [1:0] who,
    output logic       init,
    output logic [3:0] load_value,
    output logic [3:0] winner_rounds,
    output logic [3:0] loser_rounds,
    output logic [3:0] round_num,
    output logic       busy,
    output logic       match_over,
    output logic       match_winner,
    output logic       bad_who
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_PULSE,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [3:0] WIN_COUNT  = 4'(ROUNDS_TO_WIN);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [1:0] WHO_WINNER = 2'b10;
    localparam logic [1:0] WHO_LOSER  = 2'b01;

    state_t     r_state;
    logic       r_gameover_q;
    logic [7:0] r_gap_cnt;
    logic       r_replay;      // current gap follows a round that did not score
    logic       r_init;
    logic [3:0] r_load;
    logic [3:0] r_win;
    logic [3:0] r_lose;
    logic [3:0] r_round;
    logic       r_busy;
    logic       r_match_over;
    logic       r_match_winner;
    logic       r_bad_who;

    logic       w_go_edge;
    logic [3:0] w_win_inc;
    logic [3:0] w_lose_inc;
    logic [3:0] w_round_inc;

    // Only a fresh rising edge ends a round; a level left high from the
    // previous round is already in r_gameover_q and cannot score again.
    assign w_go_edge   = gameover & ~r_gameover_q;

    // Saturating increments: all counters stop at 15.
    assign w_win_inc   = (r_win   == 4'hF) ? 4'hF : r_win   + 4'd1;
    assign w_lose_inc  = (r_lose  == 4'hF) ? 4'hF : r_lose  + 4'd1;
    assign w_round_inc = (r_round == 4'hF) ? 4'hF : r_round + 4'd1;

    // NOTE: every register, including the edge-detect flop and the gap
    // counter, sits in the reset branch. The asynchronous clear then forces
    // init low immediately, even in the middle of a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_gameover_q   <= 1'b0;
            r_gap_cnt      <= 8'd0;
            r_replay       <= 1'b0;
            r_init         <= 1'b0;
            r_load         <= 4'd0;
            r_win          <= 4'd0;
            r_lose         <= 4'd0;
            r_round        <= 4'd0;
            r_busy         <= 1'b0;
            r_match_over   <= 1'b0;
            r_match_winner <= 1'b0;
            r_bad_who      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values (e.g. r_gameover_q in w_go_edge).
            r_gameover_q <= gameover;

            case (r_state)
                // A gameover edge that arrives together with start in DONE is
                // not looked at here, so the new match always wins.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_win          <= 4'd0;
                        r_lose         <= 4'd0;
                        r_bad_who      <= 1'b0;
                        r_round        <= 4'd1;
                        r_load         <= seed_value;
                        r_replay       <= 1'b0;
                        r_gap_cnt      <= 8'd0;
                        r_match_over   <= 1'b0;
                        r_match_winner <= 1'b0;
                        r_busy         <= 1'b1;
                        r_init         <= 1'b1;
                        r_state        <= S_INIT_PULSE;
                    end
                end

                S_INIT_PULSE: begin
                    r_init  <= 1'b0;
                    r_state <= S_PLAY;
                end

                S_PLAY: begin
                    if (w_go_edge) begin
                        r_gap_cnt <= 8'd0;
                        if (who == WHO_WINNER) begin
                            r_win    <= w_win_inc;
                            r_replay <= 1'b0;
                            if (w_win_inc == WIN_COUNT) begin
                                r_match_winner <= 1'b1;
                                r_match_over   <= 1'b1;
                                r_busy         <= 1'b0;
                                r_state        <= S_DONE;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else if (who == WHO_LOSER) begin
                            r_lose   <= w_lose_inc;
                            r_replay <= 1'b0;
                            if (w_lose_inc == WIN_COUNT) begin
                                r_match_winner <= 1'b0;
                                r_match_over   <= 1'b1;
                                r_busy         <= 1'b0;
                                r_state        <= S_DONE;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            // Invalid WHO: flag it and replay the same round.
                            r_bad_who <= 1'b1;
                            r_replay  <= 1'b1;
                            r_state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= 8'd0;
                        r_init    <= 1'b1;
                        r_state   <= S_INIT_PULSE;
                        if (!r_replay) begin
                            r_round <= w_round_inc;
                            r_load  <= r_load + 4'd1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end

                default: begin
                    r_init  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign init          = r_init;
    assign load_value    = r_load;
    assign winner_rounds = r_win;
    assign loser_rounds  = r_lose;
    assign round_num     = r_round;
    assign busy          = r_busy;
    assign match_over    = r_match_over;
    assign match_winner  = r_match_winner;
    assign bad_who       = r_bad_who;

endmodule

// File: tb/tb_game_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_match_ctrl
//
// Purpose:
//   Self-checking bench for game_match_ctrl with default parameters.
//   A match-level model tracks scores, round, load value and the remaining
//   gap before the next init pulse. It is compared against every DUT output
//   on each falling clock edge. Directed scenarios add hand-computed literal
//   expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_game_match_ctrl;

    localparam int R = 3;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] seed_value = 4'd0;
    logic       gameover = 1'b0;
    logic [1:0] who = 2'b00;
    logic       init;
    logic [3:0] load_value, winner_rounds, loser_rounds, round_num;
    logic       busy, match_over, match_winner, bad_who;

    game_match_ctrl #(.ROUNDS_TO_WIN(R), .GAP_CYCLES(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed_value   (seed_value),
        .gameover     (gameover),
        .who          (who),
        .init         (init),
        .load_value   (load_value),
        .winner_rounds(winner_rounds),
        .loser_rounds (loser_rounds),
        .round_num    (round_num),
        .busy         (busy),
        .match_over   (match_over),
        .match_winner (match_winner),
        .bad_who      (bad_who)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- match-level model ----------------
    bit         m_init = 0, m_play = 0, m_busy = 0, m_over = 0, m_mw = 0, m_bad = 0;
    bit         m_adv = 0, m_go_q = 0;
    logic [3:0] m_win = 0, m_lose = 0, m_round = 0, m_load = 0;
    int         m_wait = 0;   // gap cycles still to run before the next init

    always @(posedge clk or negedge rst_n) begin : model
        bit rise;
        if (!rst_n) begin
            m_init = 0; m_play = 0; m_busy = 0; m_over = 0; m_mw = 0; m_bad = 0;
            m_adv = 0; m_go_q = 0; m_win = 0; m_lose = 0; m_round = 0; m_load = 0;
            m_wait = 0;
        end else begin
            rise   = gameover && !m_go_q;
            m_go_q = gameover;
            if (m_init) begin
                m_init = 0;
                m_play = 1;
            end else if (!m_busy) begin
                if (start) begin
                    m_win = 0; m_lose = 0; m_bad = 0; m_round = 1; m_load = seed_value;
                    m_busy = 1; m_over = 0; m_mw = 0; m_init = 1; m_wait = 0;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_init = 1;
                    if (m_adv) begin
                        if (m_round != 4'd15) m_round = m_round + 4'd1;
                        m_load = m_load + 4'd1;
                    end
                end
            end else if (m_play && rise) begin
                m_play = 0;
                if (who == 2'b10 || who == 2'b01) begin
                    if (who == 2'b10) begin
                        if (m_win != 4'd15) m_win = m_win + 4'd1;
                    end else begin
                        if (m_lose != 4'd15) m_lose = m_lose + 4'd1;
                    end
                    if (int'(who == 2'b10 ? m_win : m_lose) == R) begin
                        m_busy = 0; m_over = 1; m_mw = (who == 2'b10);
                    end else begin
                        m_wait = G; m_adv = 1;
                    end
                end else begin
                    m_bad = 1; m_wait = G; m_adv = 0;
                end
            end
        end
    end

    logic [20:0] dut_vec, mdl_vec;
    assign dut_vec = {init, load_value, winner_rounds, loser_rounds, round_num,
                      busy, match_over, match_winner, bad_who};
    assign mdl_vec = {m_init, m_load, m_win, m_lose, m_round,
                      m_busy, m_over, m_mw, m_bad};

    // Field order: init,load,win,lose,round,busy,over,mwin,bad
    always @(negedge clk) check("cycle_outputs", 32'(dut_vec), 32'(mdl_vec));

    // Every init pulse, with the load value and round it carries.
    logic [3:0] q_load[$];
    logic [3:0] q_round[$];
    always @(negedge clk) if (init === 1'b1) begin
        q_load.push_back(load_value);
        q_round.push_back(round_num);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge where init is high.
    task automatic do_start(input logic [3:0] seed);
        start = 1'b1; seed_value = seed;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_init(output int at);
        int n = 0;
        while (init !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        at = cyc_n;
        if (n >= 400) check("init_timeout", 32'(init), 32'd1);
    endtask

    // Called on the falling edge where init is high. Plays one round ending
    // with a one-cycle gameover pulse. Latency counts the cycle in which
    // gameover is first high as cycle 1, up to the init cycle inclusive.
    task automatic play_round(input logic [1:0] w, input bit expect_init);
        int t0, t1;
        @(negedge clk);
        gameover = 1'b1; who = w; t0 = cyc_n;
        @(negedge clk);
        gameover = 1'b0; who = 2'b00;
        if (expect_init) begin
            wait_init(t1);
            check("init_latency", 32'(t1 - t0 + 1), 32'(G + 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        #1 rst_n = 1'b0;
        tick(2);
        check("reset_outputs", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        tick(3);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_init", 32'(init), 32'd0);

        // ---- three winner rounds from seed 1; start held through round 2 ----
        q_load.delete(); q_round.delete();
        do_start(4'd1);
        play_round(2'b10, 1'b1);
        start = 1'b1; seed_value = 4'd9;    // must be ignored mid-match
        play_round(2'b10, 1'b1);
        start = 1'b0;
        check("busy_start_ignored_round", 32'(round_num), 32'd3);
        play_round(2'b10, 1'b0);
        tick(G + 4);
        check("m1_init_count", 32'(q_load.size()), 32'd3);
        check("m1_load0", 32'(q_load[0]), 32'd1);
        check("m1_load1", 32'(q_load[1]), 32'd2);
        check("m1_load2", 32'(q_load[2]), 32'd3);
        check("m1_winner_rounds", 32'(winner_rounds), 32'd3);
        check("m1_match_over", 32'(match_over), 32'd1);
        check("m1_match_winner", 32'(match_winner), 32'd1);
        check("m1_round_num", 32'(round_num), 32'd3);
        // gameover edge in DONE is ignored
        gameover = 1'b1; who = 2'b01;
        tick(2);
        gameover = 1'b0; who = 2'b00;
        tick(3);
        check("done_hold_loser", 32'(loser_rounds), 32'd0);
        check("done_hold_over", 32'(match_over), 32'd1);

        // ---- start and gameover edge together in DONE, then alternate ----
        q_load.delete(); q_round.delete();
        start = 1'b1; seed_value = 4'd5; gameover = 1'b1; who = 2'b01;
        @(negedge clk);
        start = 1'b0; gameover = 1'b0; who = 2'b00;
        check("m2_restart_init", 32'(init), 32'd1);
        check("m2_restart_loser", 32'(loser_rounds), 32'd0);
        play_round(2'b01, 1'b1);
        play_round(2'b10, 1'b1);
        play_round(2'b01, 1'b1);
        play_round(2'b10, 1'b1);
        play_round(2'b01, 1'b0);
        tick(G + 4);
        check("m2_init_count", 32'(q_load.size()), 32'd5);
        check("m2_loser_rounds", 32'(loser_rounds), 32'd3);
        check("m2_winner_rounds", 32'(winner_rounds), 32'd2);
        check("m2_match_winner", 32'(match_winner), 32'd0);
        check("m2_last_load", 32'(q_load[4]), 32'd9);

        // ---- gameover held 20 cycles, then bad WHO in round 2 ----
        q_load.delete(); q_round.delete();
        do_start(4'd7);
        @(negedge clk);
        gameover = 1'b1; who = 2'b10;
        tick(20);
        gameover = 1'b0; who = 2'b00;
        check("held_winner_rounds", 32'(winner_rounds), 32'd1);
        check("held_init_count", 32'(q_load.size()), 32'd2);
        play_round(2'b11, 1'b1);
        check("bad_who_set", 32'(bad_who), 32'd1);
        check("bad_winner_rounds", 32'(winner_rounds), 32'd1);
        check("bad_loser_rounds", 32'(loser_rounds), 32'd0);
        check("bad_replay_round", 32'(round_num), 32'd2);
        check("bad_replay_load", 32'(load_value), 32'd8);
        play_round(2'b10, 1'b1);
        check("after_replay_round", 32'(round_num), 32'd3);
        check("after_replay_load", 32'(load_value), 32'd9);
        // score a loser round, then reset in the middle of the gap
        play_round(2'b01, 1'b0);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_vec), 32'd0);
        q_load.delete(); q_round.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2 * G + 10);
        check("post_reset_no_init", 32'(q_load.size()), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_round", 32'(round_num), 32'd0);

        // ---- seed 15 wraps to 0 in round 2 ----
        q_load.delete(); q_round.delete();
        do_start(4'd15);
        play_round(2'b10, 1'b1);
        check("wrap_load_r2", 32'(load_value), 32'd0);
        check("wrap_round_r2", 32'(round_num), 32'd2);
        play_round(2'b01, 1'b1);
        check("wrap_load_r3", 32'(load_value), 32'd1);
        play_round(2'b10, 1'b1);
        play_round(2'b10, 1'b0);
        tick(G + 2);
        check("m4_match_over", 32'(match_over), 32'd1);
        check("m4_scores", 32'({winner_rounds, loser_rounds}), 32'h31);
        check("m4_init_rounds", 32'({q_round[0], q_round[1], q_round[2], q_round[3]}), 32'h1234);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
